// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, byte width, default issue-ack timeout,
// round-robin pointer advance helper.
package uart_pkg;

    localparam int BYTE_W          = 8;
    localparam int ACK_TIMEOUT_DEF = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    // Next search start after granting idx: one past the winner, wrapping.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purpose: combinational round-robin arbiter; search starts at ptr and wraps.
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: none; caller decides whether the grant is consumed.
// Ports: req (request vector), ptr (first index searched), gnt (one-hot or
// zero), gnt_idx (binary index of gnt), gnt_any (some request granted).
// Build option UART_SCHED_PRIO_EN: requester 0 beats everyone whenever it
// requests; the remaining requesters rotate among themselves.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [N-1:0]  cand;
    logic [IW-1:0] idx;

`ifdef UART_SCHED_PRIO_EN
    // Masking down to bit 0 makes it the only candidate whatever ptr says;
    // when req[0] is low the normal rotation covers the others.
    assign cand = req[0] ? {{(N-1){1'b0}}, 1'b1} : req;
`else
    assign cand = req;
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr) + k) % N);
            if (!gnt_any && cand[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Purpose: shares one uart_tx between NUM_REQ byte requesters (round-robin).
// Latency: accept in cycle T, uart_valid in T+1; next accept after uart_tx idles.
// Backpressure: req_ready only while IDLE and uart_ready=1; others hold req_valid.
// Ports: CLK/RESETN (async active-low), req_valid/req_data/req_ready per
// requester, uart_data/uart_valid/uart_ready toward uart_tx, busy (not IDLE),
// grant_id (owner of the byte in flight), timeout_err (one-cycle pulse).
// Build option UART_SCHED_PRIO_EN gives requester 0 strict priority.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                        CLK,
    input  logic                        RESETN,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]           uart_data,
    output logic                        uart_valid,
    input  logic                        uart_ready,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t              state, state_nxt;
    logic [IW-1:0]       rr_ptr;
    logic [CW-1:0]       to_cnt, to_cnt_nxt;
    logic                to_fire;
    logic                accept;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic [BYTE_W-1:0]   sel_byte;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    // One-hot grant lets the byte mux collapse to an AND-OR tree.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_byte = sel_byte | req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = to_cnt;
        accept     = 1'b0;
        to_fire    = 1'b0;
        req_ready  = '0;
        uart_valid = 1'b0;
        case (state)
            IDLE: begin
                // RESETN in the gate keeps req_ready low during reset even
                // though the arbiter itself is purely combinational.
                if (uart_ready && RESETN && arb_any) begin
                    req_ready = arb_gnt;
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                uart_valid = 1'b1;
                to_cnt_nxt = '0;
                state_nxt  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!uart_ready) begin
                    to_cnt_nxt = '0;
                    state_nxt  = WAIT_DONE;
                end else if (to_cnt == CW'(ACK_TIMEOUT - 1)) begin
                    // uart_tx never took the byte: re-present the same one.
                    to_fire    = 1'b1;
                    to_cnt_nxt = '0;
                    state_nxt  = ISSUE;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                // Frame length belongs to uart_tx, so no timeout here.
                if (uart_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= IDLE;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
            uart_data   <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
        end else begin
            state       <= state_nxt;
            to_cnt      <= to_cnt_nxt;
            timeout_err <= to_fire;
            if (accept) begin
                uart_data <= sel_byte;
                grant_id  <= arb_idx;
                rr_ptr    <= IW'(rr_next(int'(arb_idx), NUM_REQ));
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: requesters feed bytes from per-requester lists,
// a behavioural uart_tx (10-cycle frame, MSB-first) answers uart_valid,
// and issued bytes are compared against an expected-order scoreboard.
module tb_uart_tx_sched;

    localparam int N = 4;

    logic           CLK    = 1'b0;
    logic           RESETN = 1'b0;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_data;
    logic           uart_valid;
    logic           uart_ready;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    uart_tx_sched #(
        .NUM_REQ     (N),
        .ACK_TIMEOUT (4)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .uart_data   (uart_data),
        .uart_valid  (uart_valid),
        .uart_ready  (uart_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    // requester sources
    logic [7:0] src_mem [N][8];
    int         src_cnt [N];
    int         src_idx [N];

    // observation and scoreboard queues
    int         cyc;
    logic [1:0] obs_id[$];
    logic [7:0] obs_dat[$];
    int         obs_cyc[$];
    logic       obs_to[$];
    logic [1:0] acc_id[$];
    int         acc_cyc[$];
    logic       acc_rdy[$];
    logic [1:0] exp_id[$];
    logic [7:0] exp_dat[$];

    // uart_tx model
    logic       tx_log[$];
    logic [9:0] tx_frame;
    int         tx_cnt;
    logic       stuck;
    int         to_pulses;

    task automatic update_inputs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = (src_idx[i] < src_cnt[i]);
            req_data[8*i +: 8] = req_valid[i] ? src_mem[i][src_idx[i]] : 8'h00;
        end
    endtask

    task automatic clear_bench();
        obs_id.delete(); obs_dat.delete(); obs_cyc.delete(); obs_to.delete();
        acc_id.delete(); acc_cyc.delete(); acc_rdy.delete();
        exp_id.delete(); exp_dat.delete(); tx_log.delete();
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_idx[i] = 0;
        end
        to_pulses = 0;
        stuck     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESETN     = 1'b0;
        tx_cnt     = 0;
        uart_ready = 1'b1;
        update_inputs();
        repeat (2) @(posedge CLK);
        #1;
        RESETN = 1'b1;
    endtask

    // One clock: observe at negedge, then after the posedge retire accepted
    // bytes and advance the uart_tx model.
    task automatic cycle();
        logic         v;
        logic [7:0]   d;
        logic [N-1:0] acc;
        @(negedge CLK);
        cyc++;
        v   = uart_valid;
        d   = uart_data;
        acc = req_valid & req_ready;
        if (v) begin
            obs_id.push_back(grant_id);
            obs_dat.push_back(d);
            obs_cyc.push_back(cyc);
            obs_to.push_back(timeout_err);
        end
        if (timeout_err) to_pulses++;
        if (acc != '0) begin
            for (int i = 0; i < N; i++) if (acc[i]) acc_id.push_back(2'(i));
            acc_cyc.push_back(cyc);
            acc_rdy.push_back(uart_ready);
        end
        @(posedge CLK);
        #1;
        for (int i = 0; i < N; i++) if (acc[i]) src_idx[i]++;
        if (stuck) begin
            uart_ready = 1'b1;
        end else if (tx_cnt > 0) begin
            tx_log.push_back(tx_frame[9]);
            tx_frame = {tx_frame[8:0], 1'b1};
            tx_cnt--;
            if (tx_cnt == 0) uart_ready = 1'b1;
        end else if (v && uart_ready) begin
            tx_frame   = {1'b0, d, 1'b1};
            tx_cnt     = 10;
            uart_ready = 1'b0;
        end
        update_inputs();
    endtask

    task automatic test_reset();
        clear_bench();
        RESETN     = 1'b0;
        uart_ready = 1'b1;
        src_mem[1][0] = 8'h5A;
        src_cnt[1]    = 1;
        update_inputs();
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0000 || uart_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req_ready=%b uart_valid=%b busy=%b timeout_err=%b, want 0000 0 0 0",
                     req_ready, uart_valid, busy, timeout_err);
        end
        n_checks++;
        if (uart_data !== 8'h00 || grant_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_data: uart_data=%h grant_id=%0d, want 00 0", uart_data, grant_id);
        end
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL idle_grant: req_ready=%b, want 0010", req_ready);
        end
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL comb_ready: req_ready=%b, want 1000", req_ready);
        end
        req_valid = 4'b0000;
        #1;
    endtask

    task automatic test_single();
        int         unstable;
        logic [9:0] exp_tx;
        int         tx_bad;
        clear_bench();
        do_reset();
        src_mem[2][0] = 8'hA5;
        src_cnt[2]    = 1;
        update_inputs();
        exp_id.push_back(2'd2);
        exp_dat.push_back(8'hA5);
        for (int t = 0; t < 20 && obs_id.size() == 0; t++) cycle();
        n_checks++;
        if (obs_id.size() == 0 || acc_cyc.size() == 0) begin
            n_fail++;
            $display("FAIL single_issue: no uart_valid within 20 cycles");
        end else begin
            n_checks++;
            if (obs_cyc[0] - acc_cyc[0] != 1) begin
                n_fail++;
                $display("FAIL single_latency: valid %0d cycles after accept, want 1",
                         obs_cyc[0] - acc_cyc[0]);
            end
            n_checks++;
            if (obs_id[0] !== exp_id[0] || obs_dat[0] !== exp_dat[0]) begin
                n_fail++;
                $display("FAIL single_byte: id=%0d data=%h, want id=%0d data=%h",
                         obs_id[0], obs_dat[0], exp_id[0], exp_dat[0]);
            end
            void'(obs_id.pop_front()); void'(obs_dat.pop_front());
            void'(exp_id.pop_front()); void'(exp_dat.pop_front());
        end
        unstable = 0;
        for (int t = 0; t < 30 && (busy || tx_cnt > 0); t++) begin
            cycle();
            if (busy && (uart_data !== 8'hA5 || grant_id !== 2'd2)) unstable++;
        end
        n_checks++;
        if (unstable != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_hold: %0d unstable cycles, busy=%b, want 0 and 0", unstable, busy);
        end
        n_checks++;
        if (acc_id.size() != 1 || obs_id.size() != 0) begin
            n_fail++;
            $display("FAIL single_once: accepts=%0d extra_issues=%0d, want 1 and 0",
                     acc_id.size(), obs_id.size());
        end
        exp_tx = 10'b0_10100101_1;
        tx_bad = 0;
        for (int k = 0; k < 10 && k < tx_log.size(); k++) begin
            if (tx_log[k] !== exp_tx[9-k]) tx_bad++;
        end
        n_checks++;
        if (tx_log.size() != 10 || tx_bad != 0) begin
            n_fail++;
            $display("FAIL single_txline: %0d bits, %0d wrong, want 10 bits 0101001011",
                     tx_log.size(), tx_bad);
        end
    endtask

    task automatic test_back_to_back();
        int min_gap;
        clear_bench();
        do_reset();
        src_mem[0][0] = 8'h10; src_mem[0][1] = 8'h14; src_cnt[0] = 2;
        src_mem[1][0] = 8'h11; src_cnt[1] = 1;
        src_mem[2][0] = 8'h12; src_cnt[2] = 1;
        src_mem[3][0] = 8'h13; src_cnt[3] = 1;
        update_inputs();
`ifdef UART_SCHED_PRIO_EN
        exp_id = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
        exp_dat = '{8'h10, 8'h14, 8'h11, 8'h12, 8'h13};
`else
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
`endif
        for (int t = 0; t < 200 && obs_id.size() < 5; t++) cycle();
        n_checks++;
        if (obs_id.size() < 5) begin
            n_fail++;
            $display("FAIL b2b_count: %0d issues, want 5", obs_id.size());
        end
        min_gap = 1000;
        for (int k = 1; k < obs_cyc.size(); k++) begin
            if (obs_cyc[k] - obs_cyc[k-1] < min_gap) min_gap = obs_cyc[k] - obs_cyc[k-1];
        end
        n_checks++;
        if (min_gap < 11 || to_pulses != 0) begin
            n_fail++;
            $display("FAIL b2b_spacing: min gap %0d cycles, timeouts %0d, want >=11 and 0",
                     min_gap, to_pulses);
        end
        while (exp_id.size() > 0 && obs_id.size() > 0) begin
            logic [1:0] eid, oid;
            logic [7:0] ed, od;
            eid = exp_id.pop_front(); ed = exp_dat.pop_front();
            oid = obs_id.pop_front(); od = obs_dat.pop_front();
            n_checks++;
            if (oid !== eid || od !== ed) begin
                n_fail++;
                $display("FAIL b2b_order: id=%0d data=%h, want id=%0d data=%h", oid, od, eid, ed);
            end
        end
    endtask

    task automatic test_timeout();
        clear_bench();
        do_reset();
        stuck = 1'b1;
        src_mem[1][0] = 8'h3C;
        src_cnt[1]    = 1;
        update_inputs();
        for (int t = 0; t < 40 && obs_id.size() < 3; t++) cycle();
        n_checks++;
        if (obs_id.size() < 3) begin
            n_fail++;
            $display("FAIL to_retry: %0d issues while stuck, want 3", obs_id.size());
        end else begin
            n_checks++;
            if (obs_cyc[1] - obs_cyc[0] != 5 || obs_cyc[2] - obs_cyc[1] != 5) begin
                n_fail++;
                $display("FAIL to_period: gaps %0d,%0d cycles, want 5,5",
                         obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
            end
            n_checks++;
            if (obs_to[0] !== 1'b0 || obs_to[1] !== 1'b1 || obs_to[2] !== 1'b1 || to_pulses != 2) begin
                n_fail++;
                $display("FAIL to_pulse: flags %b%b%b total %0d, want 011 total 2",
                         obs_to[0], obs_to[1], obs_to[2], to_pulses);
            end
            n_checks++;
            if (obs_dat[1] !== 8'h3C || obs_dat[2] !== 8'h3C || obs_id[2] !== 2'd1 || acc_id.size() != 1) begin
                n_fail++;
                $display("FAIL to_same_byte: data %h/%h id %0d accepts %0d, want 3c/3c 1 1",
                         obs_dat[1], obs_dat[2], obs_id[2], acc_id.size());
            end
        end
        stuck = 1'b0;
        for (int t = 0; t < 40 && (busy || tx_cnt > 0); t++) cycle();
        n_checks++;
        if (busy !== 1'b0 || obs_dat[obs_dat.size()-1] !== 8'h3C) begin
            n_fail++;
            $display("FAIL to_recover: busy=%b last=%h, want 0 3c", busy, obs_dat[obs_dat.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        clear_bench();
        do_reset();
        src_mem[1][0] = 8'h77;
        src_cnt[1]    = 1;
        update_inputs();
        for (int t = 0; t < 20 && obs_id.size() == 0; t++) cycle();
        repeat (5) cycle();
        n_checks++;
        if (busy !== 1'b1 || uart_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_setup: busy=%b uart_ready=%b, want 1 0", busy, uart_ready);
        end
        src_mem[0][0] = 8'h55; src_cnt[0] = 1;
        src_mem[3][0] = 8'h66; src_cnt[3] = 1;
        update_inputs();
        obs_id.delete(); obs_dat.delete(); obs_cyc.delete(); obs_to.delete();
        acc_id.delete(); acc_cyc.delete(); acc_rdy.delete();
        #2;
        RESETN = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || uart_valid !== 1'b0 || uart_data !== 8'h00 ||
            grant_id !== 2'd0 || req_ready !== 4'b0000 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async: busy=%b valid=%b data=%h id=%0d ready=%b to=%b, want all zero",
                     busy, uart_valid, uart_data, grant_id, req_ready, timeout_err);
        end
        repeat (2) cycle();
        RESETN = 1'b1;
        for (int t = 0; t < 40 && obs_id.size() == 0; t++) cycle();
        n_checks++;
        if (acc_id.size() == 0 || obs_id.size() == 0) begin
            n_fail++;
            $display("FAIL mid_resume: accepts=%0d issues=%0d after release, want >=1", acc_id.size(), obs_id.size());
        end else begin
            n_checks++;
            if (acc_id[0] !== 2'd0 || acc_rdy[0] !== 1'b1 || obs_dat[0] !== 8'h55) begin
                n_fail++;
                $display("FAIL mid_first: id=%0d uart_ready=%b data=%h, want 0 1 55",
                         acc_id[0], acc_rdy[0], obs_dat[0]);
            end
        end
    endtask

    task automatic test_prio();
        clear_bench();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            src_mem[0][k] = 8'hA0 + 8'(k);
            src_mem[3][k] = 8'hB0 + 8'(k);
        end
        src_cnt[0] = 3;
        src_cnt[3] = 3;
        update_inputs();
`ifdef UART_SCHED_PRIO_EN
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd3};
        exp_dat = '{8'hA0, 8'hA1, 8'hA2, 8'hB0};
`else
        exp_id = '{2'd0, 2'd3, 2'd0, 2'd3};
        exp_dat = '{8'hA0, 8'hB0, 8'hA1, 8'hB1};
`endif
        for (int t = 0; t < 200 && obs_id.size() < 4; t++) cycle();
        n_checks++;
        if (obs_id.size() < 4) begin
            n_fail++;
            $display("FAIL prio_count: %0d issues, want 4", obs_id.size());
        end
        while (exp_id.size() > 0 && obs_id.size() > 0) begin
            logic [1:0] eid, oid;
            logic [7:0] ed, od;
            eid = exp_id.pop_front(); ed = exp_dat.pop_front();
            oid = obs_id.pop_front(); od = obs_dat.pop_front();
            n_checks++;
            if (oid !== eid || od !== ed) begin
                n_fail++;
                $display("FAIL prio_order: id=%0d data=%h, want id=%0d data=%h", oid, od, eid, ed);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        req_valid  = '0;
        req_data   = '0;
        uart_ready = 1'b1;
        stuck      = 1'b0;
        tx_cnt     = 0;
        tx_frame   = '1;
        cyc        = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_prio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, number of byte requesters sharing one uart_tx (range 2..8).
REQ-002 Parameter ACK_TIMEOUT, default 4, cycles allowed for uart_ready to fall after an issue.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-valid.
REQ-006 req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8*i+7:8*i].
REQ-007 req_ready  output  NUM_REQ  per-requester accept strobe; transfer when req_valid[i] and req_ready[i] are both high.
REQ-008 uart_data  output  8  byte to uart_tx data.
REQ-009 uart_valid  output  1  to uart_tx valid.
REQ-010 uart_ready  input  1  from uart_tx ready.
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the requester whose byte is in flight.
REQ-013 timeout_err  output  1  one-cycle pulse on issue timeout.

Function
REQ-014 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE: when uart_ready=1 and any req_valid=1, round-robin winner w SHALL be chosen, req_ready[w]=1 that cycle only, and at the edge req_data[w] latches to uart_data, w to grant_id, and the state moves to ISSUE.
REQ-016 req_ready SHALL be one-hot or zero, asserted only in IDLE with uart_ready=1 and RESETN=1; req_ready depends combinationally on req_valid.
REQ-017 Round-robin: search starts at (last grant + 1) mod NUM_REQ, wrapping; the pointer updates only on an accept.
REQ-018 ISSUE: uart_valid=1 for exactly this one cycle; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: uart_ready=0 -> WAIT_DONE; otherwise count cycles, and after ACK_TIMEOUT cycles pulse timeout_err and return to ISSUE with the same byte (unbounded retries).
REQ-020 WAIT_DONE: uart_ready=1 -> IDLE; no timeout here (the 10-bit frame length is owned by uart_tx).
REQ-021 Latency: accept in cycle T, uart_valid in cycle T+1; the next accept occurs no earlier than the first IDLE cycle with uart_ready=1.
REQ-022 uart_data and grant_id SHALL be stable from ISSUE until return to IDLE.
REQ-023 Requests arriving while busy SHALL wait; requesters hold req_valid and data until accepted, and no byte is dropped or duplicated except a retry after timeout.
REQ-024 uart_valid SHALL never be high outside ISSUE.

Reset
REQ-025 RESETN low SHALL asynchronously force state IDLE, uart_valid 0, uart_data 8'h00, grant_id 0, RR pointer so that requester 0 wins first, timeout counter 0, timeout_err 0, and req_ready all 0.
REQ-026 Reset mid-frame SHALL abandon the byte; after deassertion, acceptance resumes when uart_ready=1.

Configuration
REQ-027 UART_SCHED_PRIO_EN defined: requester 0 SHALL win whenever req_valid[0]=1, and the others are round-robin among themselves; undefined: pure round-robin over all NUM_REQ.

Structure
REQ-028 Shared package uart_pkg SHALL hold the state enum, the byte width constant (8), and the ACK_TIMEOUT default.
REQ-029 Arbitration SHALL be a sub-module rr_arbiter (request vector, pointer, one-hot grant, grant index); the FSM stays in uart_tx_sched.

Verification
REQ-030 Single request: req_valid=4'b0100, data 8'hA5, uart_tx attached -> req_ready[2] pulses once, uart_valid one cycle later with uart_data=A5, and the tx line shows start, 1,0,1,0,0,1,0,1 MSB-first, then stop.
REQ-031 All four valid continuously, bytes 8'h10..8'h13 -> grant order 0,1,2,3,0; no two uart_valid pulses within one frame.
REQ-032 uart_ready tied high (model stuck) -> timeout_err pulses after 4 WAIT_BUSY cycles and uart_valid re-pulses with an unchanged byte.
REQ-033 RESETN low during WAIT_DONE -> outputs take reset values immediately (asynchronously); after release, requester 0 (if valid) is accepted first.
REQ-034 UART_SCHED_PRIO_EN defined, req 0 and req 3 both valid for 3 bytes -> three req 0 grants before req 3; undefined -> alternates 0,3,0.
